mips_fetch: RTL and testbench
=============================

MIPS_FETCH -- requirements
Module: mips_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_3000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, meaning the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1, meaning reset that is asynchronous and active-low.
REQ-004 SHALL have port imem_req, output, 1, meaning an instruction-memory read request is valid this cycle.
REQ-005 SHALL have port imem_addr, output, 32, meaning the word address for the request.
REQ-006 SHALL have port imem_ack, input, 1, meaning imem_rdata is valid this cycle.
REQ-007 SHALL have port imem_rdata, input, 32, meaning the instruction word.
REQ-008 SHALL have port br_taken, input, 1, meaning a single-cycle redirect pulse from decode (branch/jump resolved).
REQ-009 SHALL have port br_target, input, 32, meaning the redirect address.
REQ-010 SHALL have port flush, input, 1, meaning discard all in-flight and buffered fetch state (exception/eret).
REQ-011 SHALL have port flush_pc, input, 32, meaning the restart address on flush.
REQ-012 SHALL have ports id_valid (output, 1), id_instr (output, 32), id_pc (output, 32) and id_pc8 (output, 32), meaning the fetch-to-decode register contents.
REQ-013 SHALL have port id_ready, input, 1, meaning decode accepts the id_* contents this cycle (low = stall).

Function
REQ-014 SHALL use an FSM with the states S_IDLE (no request outstanding), S_WAIT (one request outstanding) and S_DROP (request outstanding, response to be discarded).
REQ-015 SHALL keep at most one request outstanding; imem_req is high only in S_IDLE, and only when the output register is empty or drains this cycle (id_valid && id_ready).
REQ-016 SHALL drive imem_addr equal to the pc register and hold it stable while imem_req is high; S_IDLE->S_WAIT on request.
REQ-017 SHALL, in S_WAIT on imem_ack, load id_instr=imem_rdata, id_pc=pc, id_pc8=pc+8, set id_valid, set pc to its next value, and return to S_IDLE.
REQ-018 SHALL make the next-pc value pc+4 (32-bit wrap-around, 32'hFFFF_FFFC+4=0), unless a redirect is pending, in which case it is br_target.
REQ-019 SHALL latch br_taken into a pending-redirect register that is consumed by the next pc advance; the in-flight or next fetch is the delay slot and is kept.
REQ-020 SHALL, on flush, clear id_valid and the pending redirect and set pc=flush_pc; a flush in S_WAIT without imem_ack goes to S_DROP, and any other flush goes to S_IDLE.
REQ-021 SHALL, in S_DROP, ignore imem_rdata and go to S_IDLE on imem_ack, with no change to pc or id_*.
REQ-022 SHALL give flush priority over br_taken and imem_ack when they occur in the same cycle.
REQ-023 SHALL clear id_valid on id_ready && id_valid when no new response arrives in the same cycle, and overwrite id_* when one does.
REQ-024 SHALL have a minimum latency of 2 cycles from imem_req to id_valid with a 1-cycle memory; throughput is 1 instruction per 2 cycles.

Reset
REQ-025 SHALL, while reset==0, hold the state at S_IDLE, pc=RESET_PC, id_valid=0, id_instr=0, id_pc=0, id_pc8=0, imem_req=0 and pending redirect=0.
REQ-026 SHALL, on reset assertion mid-request, abandon the request; the first request after release is at RESET_PC, and a stale imem_ack in S_IDLE is ignored.

Configuration
REQ-027 SHALL, with macro MIPS_FETCH_ALIGN_CHK_EN defined, add output id_adel (1 bit, reset 0); if pc[1:0]!=0, no memory request is issued, and id_valid is set with id_instr=0 (nop) and id_adel=1 one cycle later.
REQ-028 SHALL, without MIPS_FETCH_ALIGN_CHK_EN, have no id_adel port and force imem_addr[1:0] to 0.

Structure
REQ-029 SHALL take from shared package mips_pkg the constants MIPS_RESET_PC, MIPS_NOP, the 32-bit word typedef and the fetch FSM state enum.
REQ-030 SHALL place the pc register, the pending-redirect register and the next-pc mux in sub-module mips_fetch_pc.

Verification
REQ-031 SHALL cover: release reset with a 1-cycle-ack memory -> imem_addr sequence 0x3000, 0x3004, 0x3008, and id_pc8 = 0x3008 for the first instruction.
REQ-032 SHALL cover: br_taken with br_target=0x3100 while fetching 0x3004 -> 0x3004 is delivered (delay slot) and the next imem_addr is 0x3100.
REQ-033 SHALL cover: flush with flush_pc=0x4180 in S_WAIT, with ack 3 cycles later carrying 0xDEADBEEF -> the word is never presented and the next imem_addr is 0x4180.
REQ-034 SHALL cover: id_ready held low for 5 cycles -> id_* stable, no new imem_req, and fetch resumes the cycle after id_ready rises.
REQ-035 SHALL cover: reset asserted during S_WAIT -> outputs reach their reset values immediately and the first request after release is 0x3000.
REQ-036 SHALL cover: with MIPS_FETCH_ALIGN_CHK_EN, br_target=0x3102 -> no imem_req, and id_adel=1 with id_instr=0 and id_pc=0x3102.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: word type, architectural constants and the fetch FSM states.
package mips_pkg;

   typedef logic [31:0] word_t;

   localparam word_t MIPS_RESET_PC = 32'h0000_3000;
   localparam word_t MIPS_NOP      = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DROP
   } fetch_state_e;

endpackage

// File: rtl/mips_fetch_pc.sv
// Fetch PC register with pending branch redirect and next-pc selection.
module mips_fetch_pc
   import mips_pkg::*;
#(
   parameter word_t RESET_PC = MIPS_RESET_PC
) (
   input  logic  clk_i,
   input  logic  rst_ni,
   input  logic  advance_i,
   input  logic  flush_i,
   input  word_t flush_pc_i,
   input  logic  br_taken_i,
   input  word_t br_target_i,
   output word_t pc_o
);

   word_t pc_q, pc_d;
   word_t tgt_q, tgt_d;
   logic  pend_q, pend_d;
   word_t pc_next;

   always_comb begin
      pc_next = pend_q ? tgt_q : pc_q + 32'd4;
      pc_d    = pc_q;
      pend_d  = pend_q;
      tgt_d   = tgt_q;
      if (flush_i) begin
         pc_d   = flush_pc_i;
         pend_d = 1'b0;
      end else begin
         if (advance_i) begin
            pc_d   = pc_next;
            pend_d = 1'b0;
         end
         // A redirect arriving with an advance waits for the following one (delay slot).
         if (br_taken_i) begin
            pend_d = 1'b1;
            tgt_d  = br_target_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         pc_q   <= RESET_PC;
         tgt_q  <= '0;
         pend_q <= 1'b0;
      end else begin
         pc_q   <= pc_d;
         tgt_q  <= tgt_d;
         pend_q <= pend_d;
      end
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/mips_fetch.sv
// MIPS instruction fetch stage: one outstanding imem request, fetch-to-decode register.
// Optional misaligned-pc detection (id_adel) enabled by defining MIPS_FETCH_ALIGN_CHK_EN.
module mips_fetch
   import mips_pkg::*;
#(
   parameter word_t RESET_PC = MIPS_RESET_PC
) (
   input  logic  clk,
   input  logic  reset,
   output logic  imem_req,
   output word_t imem_addr,
   input  logic  imem_ack,
   input  word_t imem_rdata,
   input  logic  br_taken,
   input  word_t br_target,
   input  logic  flush,
   input  word_t flush_pc,
   output logic  id_valid,
   output word_t id_instr,
   output word_t id_pc,
   output word_t id_pc8,
`ifdef MIPS_FETCH_ALIGN_CHK_EN
   output logic  id_adel,
`endif
   input  logic  id_ready
);

   fetch_state_e state_q, state_d;
   word_t        pc;
   logic         can_load;
   logic         misaligned;
   logic         resp;
   logic         adel_load;
   logic         advance;

   mips_fetch_pc #(
      .RESET_PC (RESET_PC)
   ) u_pc (
      .clk_i       (clk),
      .rst_ni      (reset),
      .advance_i   (advance),
      .flush_i     (flush),
      .flush_pc_i  (flush_pc),
      .br_taken_i  (br_taken),
      .br_target_i (br_target),
      .pc_o        (pc)
   );

`ifdef MIPS_FETCH_ALIGN_CHK_EN
   assign misaligned = (pc[1:0] != 2'b00);
   assign imem_addr  = pc;
`else
   assign misaligned = 1'b0;
   assign imem_addr  = pc & 32'hFFFF_FFFC;
`endif

   assign can_load  = !id_valid || id_ready;
   // Reset gates the request combinationally so it drops the moment reset asserts.
   assign imem_req  = reset && (state_q == S_IDLE) && !flush && can_load && !misaligned;
   assign resp      = (state_q == S_WAIT) && imem_ack && !flush;
   assign adel_load = (state_q == S_IDLE) && misaligned && can_load && !flush;
   assign advance   = resp || adel_load;

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (!flush && imem_req) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (flush)         state_d = imem_ack ? S_IDLE : S_DROP;
            else if (imem_ack) state_d = S_IDLE;
         end
         S_DROP: begin
            if (flush || imem_ack) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         id_valid <= 1'b0;
         id_instr <= '0;
         id_pc    <= '0;
         id_pc8   <= '0;
      end else if (flush) begin
         id_valid <= 1'b0;
      end else if (resp) begin
         id_valid <= 1'b1;
         id_instr <= imem_rdata;
         id_pc    <= pc;
         id_pc8   <= pc + 32'd8;
      end else if (adel_load) begin
         id_valid <= 1'b1;
         id_instr <= MIPS_NOP;
         id_pc    <= pc;
         id_pc8   <= pc + 32'd8;
      end else if (id_valid && id_ready) begin
         id_valid <= 1'b0;
      end
   end

`ifdef MIPS_FETCH_ALIGN_CHK_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                      id_adel <= 1'b0;
      else if (flush)                  id_adel <= 1'b0;
      else if (resp)                   id_adel <= 1'b0;
      else if (adel_load)              id_adel <= 1'b1;
      else if (id_valid && id_ready)   id_adel <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_mips_fetch.sv
// Directed bench for mips_fetch with a variable-latency instruction memory model.
module tb_mips_fetch;
   import mips_pkg::*;

   logic  clk = 1'b0;
   logic  reset;
   logic  imem_req;
   word_t imem_addr;
   logic  imem_ack;
   word_t imem_rdata;
   logic  br_taken;
   word_t br_target;
   logic  flush;
   word_t flush_pc;
   logic  id_valid;
   word_t id_instr;
   word_t id_pc;
   word_t id_pc8;
   logic  id_ready;
`ifdef MIPS_FETCH_ALIGN_CHK_EN
   logic  id_adel;
`endif

   int checks = 0;
   int errors = 0;

   // Memory model: a request is answered mem_lat cycles later with addr + 0x1000_0000.
   int    mem_lat = 1;
   logic  mem_poison = 1'b0;
   logic  mem_busy = 1'b0;
   int    mem_cnt = 0;
   word_t mem_addr = '0;
   logic  seen_bad = 1'b0;

   always #5 clk = ~clk;

   mips_fetch dut (
      .clk        (clk),
      .reset      (reset),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .br_taken   (br_taken),
      .br_target  (br_target),
      .flush      (flush),
      .flush_pc   (flush_pc),
      .id_valid   (id_valid),
      .id_instr   (id_instr),
      .id_pc      (id_pc),
      .id_pc8     (id_pc8),
`ifdef MIPS_FETCH_ALIGN_CHK_EN
      .id_adel    (id_adel),
`endif
      .id_ready   (id_ready)
   );

   assign imem_ack   = mem_busy && (mem_cnt == 1);
   assign imem_rdata = mem_poison ? 32'hDEAD_BEEF : mem_addr + 32'h1000_0000;

   always @(posedge clk) begin
      if (imem_req) begin
         mem_busy <= 1'b1;
         mem_cnt  <= mem_lat;
         mem_addr <= imem_addr;
      end else if (mem_busy && mem_cnt == 1) begin
         mem_busy <= 1'b0;
      end else if (mem_busy) begin
         mem_cnt <= mem_cnt - 1;
      end
   end

   always @(negedge clk) begin
      if (id_valid && id_instr == 32'hDEAD_BEEF) seen_bad <= 1'b1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset     = 1'b0;
      br_taken  = 1'b0;
      br_target = '0;
      flush     = 1'b0;
      flush_pc  = '0;
      id_ready  = 1'b1;
      step();
      step();
      check_eq("rst_valid", {31'b0, id_valid}, 32'd0);
      check_eq("rst_req", {31'b0, imem_req}, 32'd0);
      check_eq("rst_instr", id_instr, 32'd0);
      check_eq("rst_pc", id_pc, 32'd0);
      check_eq("rst_pc8", id_pc8, 32'd0);

      // Sequential fetch from the reset vector
      reset = 1'b1;
      #1;
      check_eq("c0_req", {31'b0, imem_req}, 32'd1);
      check_eq("c0_addr", imem_addr, 32'h0000_3000);
      step();
      check_eq("c1_req", {31'b0, imem_req}, 32'd0);
      check_eq("c1_valid", {31'b0, id_valid}, 32'd0);
      step();
      check_eq("c2_valid", {31'b0, id_valid}, 32'd1);
      check_eq("c2_instr", id_instr, 32'h1000_3000);
      check_eq("c2_pc", id_pc, 32'h0000_3000);
      check_eq("c2_pc8", id_pc8, 32'h0000_3008);
      check_eq("c2_addr", imem_addr, 32'h0000_3004);
      check_eq("c2_req", {31'b0, imem_req}, 32'd1);
      // Branch resolves while 0x3004 is being fetched
      br_taken  = 1'b1;
      br_target = 32'h0000_3100;
      step();
      br_taken = 1'b0;
      check_eq("c3_valid", {31'b0, id_valid}, 32'd0);
      step();
      check_eq("dslot_pc", id_pc, 32'h0000_3004);
      check_eq("dslot_instr", id_instr, 32'h1000_3004);
      check_eq("br_addr", imem_addr, 32'h0000_3100);
      check_eq("br_req", {31'b0, imem_req}, 32'd1);
      step();
      step();
      check_eq("tgt_pc", id_pc, 32'h0000_3100);
      check_eq("tgt_instr", id_instr, 32'h1000_3100);
      check_eq("tgt_next", imem_addr, 32'h0000_3104);

      // Decode stall for 5 cycles
      id_ready = 1'b0;
      #1;
      check_eq("stall_req0", {31'b0, imem_req}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         check_eq("stall_valid", {31'b0, id_valid}, 32'd1);
         check_eq("stall_pc", id_pc, 32'h0000_3100);
         check_eq("stall_instr", id_instr, 32'h1000_3100);
         check_eq("stall_req", {31'b0, imem_req}, 32'd0);
      end
      step();
      id_ready = 1'b1;
      #1;
      check_eq("resume_req", {31'b0, imem_req}, 32'd1);
      check_eq("resume_addr", imem_addr, 32'h0000_3104);
      step();
      check_eq("drain_valid", {31'b0, id_valid}, 32'd0);
      step();
      check_eq("resume_pc", id_pc, 32'h0000_3104);
      check_eq("pre_flush_addr", imem_addr, 32'h0000_3108);

      // Flush while waiting on a slow response that must be discarded
      mem_lat    = 4;
      mem_poison = 1'b1;
      step();
      flush    = 1'b1;
      flush_pc = 32'h0000_4180;
      #1;
      check_eq("flush_req", {31'b0, imem_req}, 32'd0);
      step();
      flush = 1'b0;
      check_eq("flush_valid", {31'b0, id_valid}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         check_eq("drop_req", {31'b0, imem_req}, 32'd0);
         step();
      end
      check_eq("restart_req", {31'b0, imem_req}, 32'd1);
      check_eq("restart_addr", imem_addr, 32'h0000_4180);
      mem_lat    = 1;
      mem_poison = 1'b0;
      step();
      step();
      check_eq("restart_pc", id_pc, 32'h0000_4180);
      check_eq("restart_instr", id_instr, 32'h1000_4180);
      check_eq("restart_pc8", id_pc8, 32'h0000_4188);
      check_eq("restart_next", imem_addr, 32'h0000_4184);
      check_eq("never_deadbeef", {31'b0, seen_bad}, 32'd0);

      // Reset while a request is outstanding
      step();
      reset = 1'b0;
      #1;
      check_eq("mid_rst_valid", {31'b0, id_valid}, 32'd0);
      check_eq("mid_rst_req", {31'b0, imem_req}, 32'd0);
      check_eq("mid_rst_instr", id_instr, 32'd0);
      check_eq("mid_rst_pc", id_pc, 32'd0);
      check_eq("mid_rst_pc8", id_pc8, 32'd0);
      step();
      step();
      reset = 1'b1;
      #1;
      check_eq("rerst_req", {31'b0, imem_req}, 32'd1);
      check_eq("rerst_addr", imem_addr, 32'h0000_3000);

      // Misaligned branch target
      br_taken  = 1'b1;
      br_target = 32'h0000_3102;
      step();
      br_taken = 1'b0;
      step();
      check_eq("mis_prev_pc", id_pc, 32'h0000_3000);
`ifdef MIPS_FETCH_ALIGN_CHK_EN
      check_eq("adel_noreq", {31'b0, imem_req}, 32'd0);
      step();
      check_eq("adel_flag", {31'b0, id_adel}, 32'd1);
      check_eq("adel_valid", {31'b0, id_valid}, 32'd1);
      check_eq("adel_instr", id_instr, 32'd0);
      check_eq("adel_pc", id_pc, 32'h0000_3102);
      check_eq("adel_noreq2", {31'b0, imem_req}, 32'd0);
`else
      check_eq("mis_req", {31'b0, imem_req}, 32'd1);
      check_eq("mis_addr", imem_addr, 32'h0000_3100);
      step();
      check_eq("mis_wait_req", {31'b0, imem_req}, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
